// File: rtl/inst_trace_buf.sv
// Retired-instruction trace recorder: circular buffer of {pc, instr, mnemonic} that
// freezes a fixed number of entries after a PC-match or BREAK trigger; drained via a pop port.
module inst_trace_buf #(
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic                     wb_valid,
    input  logic [31:0]              wb_pc,
    input  logic [31:0]              wb_instr,
    input  logic [39:0]              wb_ascii,
    input  logic                     trig_pc_en,
    input  logic [31:0]              trig_pc,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_instr,
    output logic [39:0]              rd_ascii,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frozen,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_post;
    logic            r_overflow;
    logic            r_rd_valid;
    logic [31:0]     r_rd_pc;
    logic [31:0]     r_rd_instr;
    logic [39:0]     r_rd_ascii;
    logic [103:0]    r_mem [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_brk;
    logic w_trig;
    logic w_post_done;

    assign w_push      = wb_valid & cap_en & ((r_state == S_RUN) | (r_state == S_POST));
    assign w_pop       = rd_en & cap_en & (r_count != {CW{1'b0}});
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_brk       = (wb_instr[31:26] == 6'd0) & (wb_instr[5:0] == 6'b001101);
    assign w_trig      = w_push & (r_state == S_RUN) & ((trig_pc_en & (wb_pc == trig_pc)) | w_brk);
    assign w_post_done = w_push & (r_state == S_POST) & (r_post == CW'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping cap_en returns to IDLE from anywhere
    always_comb begin
        w_state_nxt = r_state;
        if (!cap_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_trig) begin
                        w_state_nxt = (POST_CNT == 0) ? S_FROZEN : S_POST;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_POST: begin
                    if (w_post_done) begin
                        w_state_nxt = S_FROZEN;
                    end else begin
                        w_state_nxt = S_POST;
                    end
                end
                S_FROZEN: w_state_nxt = S_FROZEN;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Trace storage; the pop path reads the pre-write value of a shared slot
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wb_pc, wb_instr, wb_ascii};
        end
    end

    // Pointers, occupancy, post-trigger countdown and pop output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_post     <= {CW{1'b0}};
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_pc    <= 32'd0;
            r_rd_instr <= 32'd0;
            r_rd_ascii <= 40'd0;
        end else if (!cap_en) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_post     <= {CW{1'b0}};
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                {r_rd_pc, r_rd_instr, r_rd_ascii} <= r_mem[r_rd_ptr];
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            // A push into a full buffer without a pop evicts the oldest entry
            if (w_pop || (w_push && w_full)) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop && !w_full) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && !w_pop && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_trig) begin
                r_post <= CW'(POST_CNT);
            end else if (w_push && (r_state == S_POST)) begin
                r_post <= r_post - CW'(1);
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_pc    = r_rd_pc;
    assign rd_instr = r_rd_instr;
    assign rd_ascii = r_rd_ascii;
    assign count    = r_count;
    assign frozen   = (r_state == S_FROZEN);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_inst_trace_buf.sv
// Directed self-checking bench for inst_trace_buf; a second instance with POST_CNT=0
// covers the immediate-freeze BREAK case.
module tb_inst_trace_buf;
    logic        clk;
    logic        rst;
    logic        cap_en;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_instr;
    logic [39:0] wb_ascii;
    logic        trig_pc_en;
    logic [31:0] trig_pc;
    logic        rd_en;

    logic        rd_valid,  rd_valid0;
    logic [31:0] rd_pc,     rd_pc0;
    logic [31:0] rd_instr,  rd_instr0;
    logic [39:0] rd_ascii,  rd_ascii0;
    logic [4:0]  count,     count0;
    logic        frozen,    frozen0;
    logic        overflow,  overflow0;

    int n_checks = 0;
    int n_fail   = 0;

    inst_trace_buf #(.DEPTH(16), .POST_CNT(4)) u_dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_instr(wb_instr), .wb_ascii(wb_ascii), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_ascii(rd_ascii), .count(count), .frozen(frozen), .overflow(overflow)
    );

    inst_trace_buf #(.DEPTH(16), .POST_CNT(0)) u_dut0 (
        .clk(clk), .rst(rst), .cap_en(cap_en), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_instr(wb_instr), .wb_ascii(wb_ascii), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
        .rd_en(rd_en), .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_instr(rd_instr0),
        .rd_ascii(rd_ascii0), .count(count0), .frozen(frozen0), .overflow(overflow0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_instr = ins;
        wb_ascii = {pc[7:0], 32'h4E4F5020};
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic arm();
        cap_en = 1'b0;
        @(negedge clk);
        cap_en = 1'b1;
        @(negedge clk);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        rst = 1'b1; cap_en = 1'b0; wb_valid = 1'b0; wb_pc = 32'd0; wb_instr = 32'd0;
        wb_ascii = 40'd0; trig_pc_en = 1'b0; trig_pc = 32'd0; rd_en = 1'b0;
        #2;
        check_eq("rst_count",    64'(count),    64'd0);
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_frozen",   64'(frozen),   64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic push/pop order and empty pop
        arm();
        push(32'h100, NOP);
        push(32'h104, 32'h1234_5678);
        push(32'h108, NOP);
        check_eq("t2_count", 64'(count), 64'd3);
        pop();
        check_eq("t2_v0",   64'(rd_valid), 64'd1);
        check_eq("t2_pc0",  64'(rd_pc),    64'h100);
        check_eq("t2_asc0", 64'(rd_ascii), 64'h00_4E4F5020);
        pop();
        check_eq("t2_pc1",  64'(rd_pc),    64'h104);
        check_eq("t2_ins1", 64'(rd_instr), 64'h1234_5678);
        pop();
        check_eq("t2_pc2",  64'(rd_pc),    64'h108);
        check_eq("t2_cnt0", 64'(count),    64'd0);
        pop();
        check_eq("t2_empty_v",   64'(rd_valid), 64'd0);
        check_eq("t2_hold_pc",   64'(rd_pc),    64'h108);

        // Asynchronous reset in the middle of RUN with count=5
        for (int i = 0; i < 6; i++) push(32'h40 + 32'(4 * i), NOP);
        pop();
        check_eq("t1_pre_count", 64'(count),    64'd5);
        check_eq("t1_pre_valid", 64'(rd_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t1_count",    64'(count),    64'd0);
        check_eq("t1_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("t1_frozen",   64'(frozen),   64'd0);
        check_eq("t1_overflow", 64'(overflow), 64'd0);
        check_eq("t1_rd_pc",    64'(rd_pc),    64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Overflow: 20 pushes into 16 slots
        arm();
        for (int i = 0; i < 20; i++) push(32'(4 * i), NOP);
        check_eq("t3_count",    64'(count),    64'd16);
        check_eq("t3_overflow", 64'(overflow), 64'd1);
        pop();
        check_eq("t3_pc", 64'(rd_pc), 64'h10);

        // PC trigger at 0x200 with four post entries
        arm();
        check_eq("t4_ovf_clr", 64'(overflow), 64'd0);
        trig_pc_en = 1'b1;
        trig_pc    = 32'h200;
        for (int i = 0; i < 13; i++) begin
            push(32'h1F0 + 32'(4 * i), NOP);
            if (i == 7) check_eq("t4_not_frozen", 64'(frozen), 64'd0);
            if (i == 8) check_eq("t4_frozen",     64'(frozen), 64'd1);
        end
        check_eq("t4_count", 64'(count), 64'd9);
        for (int i = 0; i < 9; i++) begin
            pop();
            check_eq("t4_drain", 64'(rd_pc), 64'(32'h1F0 + 32'(4 * i)));
        end
        pop();
        check_eq("t4_empty_v", 64'(rd_valid), 64'd0);
        trig_pc_en = 1'b0;

        // BREAK trigger: immediate freeze with POST_CNT=0, four post entries otherwise
        arm();
        push(32'h500, 32'h0000_000D);
        check_eq("t5_frozen0", 64'(frozen0), 64'd1);
        check_eq("t5_frozen",  64'(frozen),  64'd0);
        for (int i = 1; i < 4; i++) push(32'h500 + 32'(4 * i), NOP);
        check_eq("t5_count0",     64'(count0), 64'd1);
        check_eq("t5_count_post", 64'(count),  64'd4);
        check_eq("t5_still_post", 64'(frozen), 64'd0);
        push(32'h510, 32'h0000_000D);
        push(32'h514, NOP);
        check_eq("t5_count_frz", 64'(count),  64'd5);
        check_eq("t5_frz",       64'(frozen), 64'd1);
        check_eq("t5_count0b",   64'(count0), 64'd1);

        // Full buffer with simultaneous push and pop, then disarm
        cap_en = 1'b0;
        @(negedge clk);
        check_eq("t6_frz_clr", 64'(frozen), 64'd0);
        cap_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) push(32'h300 + 32'(4 * i), NOP);
        check_eq("t6_full", 64'(count), 64'd16);
        wb_valid = 1'b1; wb_pc = 32'h400; wb_instr = NOP; wb_ascii = 40'd0; rd_en = 1'b1;
        @(negedge clk);
        wb_valid = 1'b0; rd_en = 1'b0;
        check_eq("t6_rdv",      64'(rd_valid), 64'd1);
        check_eq("t6_oldest",   64'(rd_pc),    64'h300);
        check_eq("t6_count",    64'(count),    64'd16);
        check_eq("t6_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 15; i++) begin
            pop();
            check_eq("t6_drain", 64'(rd_pc), 64'(32'h304 + 32'(4 * i)));
        end
        pop();
        check_eq("t6_newest", 64'(rd_pc), 64'h400);
        push(32'h600, NOP);
        push(32'h604, NOP);
        cap_en = 1'b0;
        @(negedge clk);
        check_eq("t6_clr_count",  64'(count),  64'd0);
        check_eq("t6_clr_frozen", 64'(frozen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
